// File: rtl/reg_read_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// reg_read_ctrl_pipe
//   Decode-stage register read controller. Picks the register-file read
//   addresses from the fetched instruction, tracks in-flight destinations in a
//   NUM_STAGES-deep scoreboard and stalls on read-after-write hazards. Issued
//   instructions are registered into the D/X latch.
//
//   Optional feature macro: REG_READ_BYPASS_EN
//     defined   : hazards on non-load entries are bypassed (o_fwd_a/o_fwd_b
//                 select stage k+1 of the youngest match); only a load sitting
//                 in the X stage stalls (one cycle).
//     undefined : every hazard stalls and o_fwd_a/o_fwd_b stay 0.
//
// Ports
//   i_clock     system clock, rising edge
//   i_reset     synchronous active-high reset, clears all state
//   i_in_valid  i_ir holds a real instruction
//   i_flush     squash current instruction, D/X loads a bubble
//   i_ir        instruction from the F/D latch
//   o_read_a    regfile port A address (combinational)
//   o_read_b    regfile port B address (combinational)
//   o_stall     hold F/D and PC (combinational)
//   o_dx_valid  D/X latch holds a real instruction (registered)
//   o_dx_ir     D/X latch instruction (registered)
//   o_fwd_a     bypass select for A, 0 = regfile, k = stage k (registered)
//   o_fwd_b     bypass select for B (registered)
// ---------------------------------------------------------------------------
module reg_read_ctrl_pipe #(
    parameter int IR_W        = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_STAGES  = 3,
    parameter int RA_IDX      = 31,
    parameter int RSTATUS_IDX = 30
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic                                  i_in_valid,
    input  logic                                  i_flush,
    input  logic [IR_W-1:0]                       i_ir,
    output logic [REG_AW-1:0]                     o_read_a,
    output logic [REG_AW-1:0]                     o_read_b,
    output logic                                  o_stall,
    output logic                                  o_dx_valid,
    output logic [IR_W-1:0]                       o_dx_ir,
    output logic [$clog2(NUM_STAGES+1)-1:0]       o_fwd_a,
    output logic [$clog2(NUM_STAGES+1)-1:0]       o_fwd_b
);
    localparam int FWD_W = $clog2(NUM_STAGES + 1);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // Instruction fields: opcode, rd, rs, rt packed from the top down
    logic [4:0]        w_opcode;
    logic [REG_AW-1:0] w_rd, w_rs, w_rt;
    assign w_opcode = i_ir[IR_W-1 -: 5];
    assign w_rd     = i_ir[IR_W-6 -: REG_AW];
    assign w_rs     = i_ir[IR_W-6-REG_AW -: REG_AW];
    assign w_rt     = i_ir[IR_W-6-2*REG_AW -: REG_AW];

    logic [REG_AW-1:0] w_read_a, w_read_b, w_dest;
    logic              w_use_a, w_use_b, w_wr_en;

    always_comb begin
        w_read_a = w_rs;
        w_read_b = w_rt;
        w_use_a  = 1'b0;
        w_use_b  = 1'b0;
        w_wr_en  = 1'b0;
        w_dest   = w_rd;
        case (w_opcode)
            OP_ALU:  begin w_use_a = 1'b1; w_use_b = 1'b1; w_wr_en = 1'b1; end
            OP_ADDI,
            OP_LW:   begin w_use_a = 1'b1; w_wr_en = 1'b1; end
            OP_SW:   begin w_read_a = w_rs; w_read_b = w_rd; w_use_a = 1'b1; w_use_b = 1'b1; end
            OP_BLT,
            OP_BNE:  begin w_read_a = w_rd; w_read_b = w_rs; w_use_a = 1'b1; w_use_b = 1'b1; end
            OP_JR:   begin w_read_a = w_rd; w_read_b = w_rs; w_use_a = 1'b1; end
            OP_BEX:  begin w_read_a = REG_AW'(RSTATUS_IDX); w_read_b = '0; w_use_a = 1'b1; end
            OP_JAL:  begin w_wr_en = 1'b1; w_dest = REG_AW'(RA_IDX); end
            OP_SETX: begin w_wr_en = 1'b1; w_dest = REG_AW'(RSTATUS_IDX); end
            default: ;
        endcase
    end

    assign o_read_a = w_read_a;
    assign o_read_b = w_read_b;

    // Scoreboard: entry 0 is the X stage, the last entry retires each cycle
    logic              r_sb_valid [NUM_STAGES];
    logic [REG_AW-1:0] r_sb_dest  [NUM_STAGES];
`ifdef REG_READ_BYPASS_EN
    logic              r_sb_load  [NUM_STAGES];
`endif

    logic [NUM_STAGES-1:0] w_match_a, w_match_b;
    logic                  w_issue;
    logic                  w_stall_cond;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sb
            // Reads of r0 never hazard; writes to r0 never enter as valid
            assign w_match_a[gi] = r_sb_valid[gi] && w_use_a && (w_read_a != '0)
                                   && (r_sb_dest[gi] == w_read_a);
            assign w_match_b[gi] = r_sb_valid[gi] && w_use_b && (w_read_b != '0)
                                   && (r_sb_dest[gi] == w_read_b);
            if (gi == 0) begin : g_head
                always_ff @(posedge i_clock) begin
                    if (i_reset) begin
                        r_sb_valid[gi] <= 1'b0;
                        r_sb_dest[gi]  <= '0;
                    end else begin
                        r_sb_valid[gi] <= w_issue && w_wr_en && (w_dest != '0);
                        r_sb_dest[gi]  <= w_issue ? w_dest : '0;
                    end
                end
`ifdef REG_READ_BYPASS_EN
                always_ff @(posedge i_clock) begin
                    if (i_reset) r_sb_load[gi] <= 1'b0;
                    else         r_sb_load[gi] <= w_issue && (w_opcode == OP_LW);
                end
`endif
            end else begin : g_tail
                always_ff @(posedge i_clock) begin
                    if (i_reset) begin
                        r_sb_valid[gi] <= 1'b0;
                        r_sb_dest[gi]  <= '0;
                    end else begin
                        r_sb_valid[gi] <= r_sb_valid[gi-1];
                        r_sb_dest[gi]  <= r_sb_dest[gi-1];
                    end
                end
`ifdef REG_READ_BYPASS_EN
                always_ff @(posedge i_clock) begin
                    if (i_reset) r_sb_load[gi] <= 1'b0;
                    else         r_sb_load[gi] <= r_sb_load[gi-1];
                end
`endif
            end
        end
    endgenerate

    logic [FWD_W-1:0] w_fwd_a_next, w_fwd_b_next;

`ifdef REG_READ_BYPASS_EN
    // Only a load still in X cannot be bypassed; everything else forwards
    // from the youngest matching stage (lowest index wins).
    assign w_stall_cond = r_sb_load[0] && (w_match_a[0] || w_match_b[0]);

    always_comb begin
        w_fwd_a_next = '0;
        w_fwd_b_next = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (w_match_a[k]) w_fwd_a_next = FWD_W'(k + 1);
            if (w_match_b[k]) w_fwd_b_next = FWD_W'(k + 1);
        end
    end
`else
    assign w_stall_cond = (|w_match_a) || (|w_match_b);
    assign w_fwd_a_next = '0;
    assign w_fwd_b_next = '0;
`endif

    assign o_stall = i_in_valid && !i_flush && w_stall_cond;
    assign w_issue = i_in_valid && !i_flush && !o_stall;

    // D/X latch: bubble (all zero) whenever nothing issues
    logic             r_dx_valid;
    logic [IR_W-1:0]  r_dx_ir;
    logic [FWD_W-1:0] r_fwd_a, r_fwd_b;

    always_ff @(posedge i_clock) begin
        if (i_reset || !w_issue) begin
            r_dx_valid <= 1'b0;
            r_dx_ir    <= '0;
            r_fwd_a    <= '0;
            r_fwd_b    <= '0;
        end else begin
            r_dx_valid <= 1'b1;
            r_dx_ir    <= i_ir;
            r_fwd_a    <= w_fwd_a_next;
            r_fwd_b    <= w_fwd_b_next;
        end
    end

    assign o_dx_valid = r_dx_valid;
    assign o_dx_ir    = r_dx_ir;
    assign o_fwd_a    = r_fwd_a;
    assign o_fwd_b    = r_fwd_b;

endmodule

// File: tb/tb_reg_read_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_read_ctrl_pipe
//   Directed bench for reg_read_ctrl_pipe. Expected D/X contents are pushed to
//   a queue when an instruction is presented and popped after the next edge.
//   The bypass section is built only when REG_READ_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_reg_read_ctrl_pipe;
    logic        clk = 1'b0;
    logic        i_reset, i_in_valid, i_flush;
    logic [31:0] i_ir;
    logic [4:0]  o_read_a, o_read_b;
    logic        o_stall, o_dx_valid;
    logic [31:0] o_dx_ir;
    logic [1:0]  o_fwd_a, o_fwd_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    reg_read_ctrl_pipe dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_in_valid (i_in_valid),
        .i_flush    (i_flush),
        .i_ir       (i_ir),
        .o_read_a   (o_read_a),
        .o_read_b   (o_read_b),
        .o_stall    (o_stall),
        .o_dx_valid (o_dx_valid),
        .o_dx_ir    (o_dx_ir),
        .o_fwd_a    (o_fwd_a),
        .o_fwd_b    (o_fwd_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        logic [11:0] imm;
        imm = 12'($urandom_range(0, 4095));
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs and check the combinational read addresses
    task automatic peek(input logic v, input logic [31:0] ir,
                        input logic [4:0] ea, input logic [4:0] eb, input string tag);
        i_in_valid = v; i_flush = 1'b0; i_ir = ir;
        #1;
        chk(32'(o_read_a), 32'(ea), {tag, "/read_a"});
        chk(32'(o_read_b), 32'(eb), {tag, "/read_b"});
    endtask

    // One clock: drive, check stall mid-cycle, check D/X after the edge
    task automatic step(input logic v, input logic f, input logic [31:0] ir,
                        input logic exp_stall, input logic [1:0] efa,
                        input logic [1:0] efb, input string tag);
        exp_t e;
        i_in_valid = v; i_flush = f; i_ir = ir;
        @(negedge clk);
        chk(32'(o_stall), 32'(exp_stall), {tag, "/stall"});
        if (v && !f && !exp_stall) e = '{1'b1, ir, efa, efb};
        else                       e = '{1'b0, 32'h0, 2'd0, 2'd0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk(32'(o_dx_valid), 32'(e.v), {tag, "/dx_valid"});
        chk(o_dx_ir, e.ir, {tag, "/dx_ir"});
        chk(32'(o_fwd_a), 32'(e.fa), {tag, "/fwd_a"});
        chk(32'(o_fwd_b), 32'(e.fb), {tag, "/fwd_b"});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, "idle");
    endtask

    logic [31:0] ins_a, ins_b;

    initial begin
        i_reset = 1'b1; i_in_valid = 1'b1; i_flush = 1'b0;
        i_ir = enc(OP_ALU, 5'd1, 5'd2, 5'd3);
        @(posedge clk); @(posedge clk); #1;
        chk(32'(o_dx_valid), 32'd0, "reset/dx_valid");
        chk(o_dx_ir, 32'h0, "reset/dx_ir");
        chk(32'(o_fwd_a), 32'd0, "reset/fwd_a");
        chk(32'(o_fwd_b), 32'd0, "reset/fwd_b");
        i_reset = 1'b0;

        // Idle after reset
        peek(1'b0, 32'h0, 5'd0, 5'd0, "idle_rd");
        step(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, "idle0");

        // Address map checks (no issue)
        peek(1'b0, enc(OP_SW, 5'd7, 5'd2, 5'd0), 5'd2, 5'd7, "sw_map");
        peek(1'b0, enc(OP_BNE, 5'd8, 5'd9, 5'd4), 5'd8, 5'd9, "bne_map");
        peek(1'b0, enc(OP_JR, 5'd5, 5'd6, 5'd4), 5'd5, 5'd6, "jr_map");
        peek(1'b0, enc(OP_BEX, 5'd1, 5'd2, 5'd3), 5'd30, 5'd0, "bex_map");

        // Write to r0 never creates a hazard
        step(1'b1, 1'b0, enc(OP_ADDI, 5'd0, 5'd1, 5'd0), 1'b0, 2'd0, 2'd0, "addi_r0");
        step(1'b1, 1'b0, enc(OP_ALU, 5'd6, 5'd0, 5'd0), 1'b0, 2'd0, 2'd0, "read_r0");
        idle(3);

`ifndef REG_READ_BYPASS_EN
        // RAW: stall through all three scoreboard stages including retiring one
        step(1'b1, 1'b0, enc(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b0, 2'd0, 2'd0, "add_r3");
        ins_b = enc(OP_ALU, 5'd4, 5'd3, 5'd5);
        peek(1'b1, ins_b, 5'd3, 5'd5, "add_r4_rd");
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "raw_x");
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "raw_m");
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "raw_w");
        step(1'b1, 1'b0, ins_b, 1'b0, 2'd0, 2'd0, "raw_issue");

        // bex waits for setx to retire
        step(1'b1, 1'b0, enc(OP_SETX, 5'd0, 5'd0, 5'd0), 1'b0, 2'd0, 2'd0, "setx");
        step(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, "gap");
        ins_a = enc(OP_BEX, 5'd0, 5'd0, 5'd0);
        peek(1'b1, ins_a, 5'd30, 5'd0, "bex_rd");
        step(1'b1, 1'b0, ins_a, 1'b1, 2'd0, 2'd0, "bex_m");
        step(1'b1, 1'b0, ins_a, 1'b1, 2'd0, 2'd0, "bex_w");
        step(1'b1, 1'b0, ins_a, 1'b0, 2'd0, 2'd0, "bex_issue");
        idle(3);

        // Flush with a pending stall, then no stall while in_valid is low
        step(1'b1, 1'b0, enc(OP_ALU, 5'd2, 5'd1, 5'd1), 1'b0, 2'd0, 2'd0, "add_r2");
        ins_a = enc(OP_SW, 5'd7, 5'd2, 5'd0);
        peek(1'b1, ins_a, 5'd2, 5'd7, "sw_rd");
        step(1'b1, 1'b0, ins_a, 1'b1, 2'd0, 2'd0, "sw_stall");
        step(1'b1, 1'b1, ins_a, 1'b0, 2'd0, 2'd0, "sw_flush");
        step(1'b0, 1'b0, ins_a, 1'b0, 2'd0, 2'd0, "sw_invalid");
        idle(2);

        // Load-use without bypass also stalls three cycles
        step(1'b1, 1'b0, enc(OP_LW, 5'd10, 5'd1, 5'd0), 1'b0, 2'd0, 2'd0, "lw_r10");
        ins_b = enc(OP_ALU, 5'd11, 5'd1, 5'd10);
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "lu_x");
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "lu_m");
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "lu_w");
        step(1'b1, 1'b0, ins_b, 1'b0, 2'd0, 2'd0, "lu_issue");
        idle(3);

        // Reset during a stall clears the scoreboard
        step(1'b1, 1'b0, enc(OP_ALU, 5'd9, 5'd1, 5'd1), 1'b0, 2'd0, 2'd0, "add_r9");
        ins_b = enc(OP_ALU, 5'd12, 5'd9, 5'd1);
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "r9_stall");
        i_reset = 1'b1;
        @(posedge clk); #1;
        chk(32'(o_dx_valid), 32'd0, "rst_stall/dx_valid");
        i_reset = 1'b0;
        step(1'b1, 1'b0, ins_b, 1'b0, 2'd0, 2'd0, "post_rst");
`else
        // Load-use: one stall, then forward from stage 2 on both ports
        step(1'b1, 1'b0, enc(OP_LW, 5'd3, 5'd1, 5'd0), 1'b0, 2'd0, 2'd0, "lw_r3");
        ins_b = enc(OP_ALU, 5'd4, 5'd3, 5'd3);
        step(1'b1, 1'b0, ins_b, 1'b1, 2'd0, 2'd0, "lu_stall");
        step(1'b1, 1'b0, ins_b, 1'b0, 2'd2, 2'd2, "lu_fwd");
        idle(3);

        // ALU result forwarded from X
        step(1'b1, 1'b0, enc(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b0, 2'd0, 2'd0, "add_r3");
        step(1'b1, 1'b0, enc(OP_ALU, 5'd4, 5'd3, 5'd1), 1'b0, 2'd1, 2'd0, "fwd_x");
        // r3 now in M, r4 in X: youngest match per port
        step(1'b1, 1'b0, enc(OP_ALU, 5'd5, 5'd3, 5'd4), 1'b0, 2'd2, 2'd1, "fwd_mx");
        idle(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
